dot_accum: RTL and testbench

//  - Sequential consumer of the 2-tap signed dot-product datapath. Takes its 13-bit signed partial sums one per handshake.
//  - Accumulates LEN partials into one result. Emits that result saturated to OUT_W bits, with a saturation flag.
//  - Sits between the combinational dot-product stage and the downstream result sink. Valid/ready handshake on both sides.

---
 rtl/dot_pkg.sv | 16 +
 rtl/dot_accum_sat_clamp.sv | 27 ++
 rtl/dot_accum.sv | 88 ++++++++
 tb/tb_dot_accum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared types, widths and helpers for the dot-product accumulator slice.
package dot_pkg;

  typedef enum logic {ACCUM, DONE} dot_state_t;

  localparam int DOT_IN_W  = 13;
  localparam int DOT_OUT_W = 14;
  localparam int DOT_LEN   = 8;
  localparam int DOT_ACC_W = DOT_IN_W + $clog2(DOT_LEN);

  // Sign-extend one partial sum to accumulator width.
  function automatic logic signed [DOT_ACC_W-1:0] sext_acc(input logic signed [DOT_IN_W-1:0] x);
    return DOT_ACC_W'(x);
  endfunction

endpackage

// File: rtl/dot_accum_sat_clamp.sv
// Combinational signed saturation from IN_W down to OUT_W bits, with a clamp flag.
module sat_clamp #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    data = value[OUT_W-1:0];
    sat  = 1'b0;
    if (value > MAX_V) begin
      data = {1'b0, {(OUT_W-1){1'b1}}};
      sat  = 1'b1;
    end else if (value < MIN_V) begin
      data = {1'b1, {(OUT_W-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/dot_accum.sv
// Accumulates LEN signed partial sums per result and hands out the saturated total
// over a valid/ready handshake.
module dot_accum
  import dot_pkg::*;
#(
  parameter int IN_W  = DOT_IN_W,
  parameter int OUT_W = DOT_OUT_W,
  parameter int LEN   = DOT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int ACC_W = IN_W + $clog2(LEN);
  localparam int CNT_W = $clog2(LEN);

  dot_state_t              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [OUT_W-1:0] clamp_data;
  logic                    clamp_sat;
  logic                    in_fire;
  logic                    last;

  // Both handshake outputs are pure decodes of the state register.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign in_fire   = in_valid & in_ready;
  assign last      = (cnt == CNT_W'(LEN - 1));
  assign acc_next  = acc + sext_acc(in_data);

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(OUT_W)
  ) u_clamp (
    .value(acc_next),
    .data (clamp_data),
    .sat  (clamp_sat)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      // Abort wins over any transfer this cycle; out_data keeps its stale value.
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sat <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            if (last) begin
              out_data <= clamp_data;
              out_sat  <= clamp_sat;
              acc      <= '0;
              cnt      <= '0;
              state    <= DONE;
            end else begin
              acc <= acc_next;
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: table-driven result vectors plus hand-written
// back-pressure, clear and asynchronous-reset sequences.
module tb_dot_accum;

  logic               clk;
  logic               rst;
  logic               clear;
  logic signed [12:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [13:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  dot_accum dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][12:0] d;
    logic [7:0][2:0]  gap;
    logic             rnd_gap;
    logic [13:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one partial and hold it until it is taken, bounded by a cycle budget.
  task automatic send(input logic signed [12:0] d);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic signed [12:0] d);
    for (int k = 0; k < n; k++) send(d);
  endtask

  task automatic expect_result(input string name, input int exp_data, input int exp_sat);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_data"}, int'(out_data), exp_data);
    check({name, "_sat"}, int'(out_sat), exp_sat);
    check({name, "_inrdy"}, int'(in_ready), 0);
  endtask

  task automatic collect(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop"}, int'(out_valid), 0);
    check({name, "_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    int g;
    logic signed [13:0] held;

    // 0: 8 x +100; 1: 8 x 4095; 2: 8 x -4096; 3: mixed with random gaps;
    // 4: exactly +8191; 5: exactly -8192; 6: +8192 just past the top.
    vecs[0] = '{d: {8{13'sd100}}, gap: '0, rnd_gap: 1'b0, exp_data: 14'sd800, exp_sat: 1'b0};
    vecs[1] = '{d: {8{13'sd4095}}, gap: '0, rnd_gap: 1'b0, exp_data: 14'sd8191, exp_sat: 1'b1};
    vecs[2] = '{d: {8{-13'sd4096}}, gap: '0, rnd_gap: 1'b0, exp_data: -14'sd8192, exp_sat: 1'b1};
    vecs[3] = '{d: {13'sd1, 13'sd2, -13'sd7, 13'sd7, -13'sd1, 13'sd0, 13'sd5, -13'sd3},
                gap: '0, rnd_gap: 1'b1, exp_data: 14'sd4, exp_sat: 1'b0};
    vecs[4] = '{d: {13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd1, 13'sd4095, 13'sd4095},
                gap: {3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd0}, rnd_gap: 1'b0,
                exp_data: 14'sd8191, exp_sat: 1'b0};
    vecs[5] = '{d: {13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, -13'sd4096, -13'sd4096},
                gap: '0, rnd_gap: 1'b0, exp_data: -14'sd8192, exp_sat: 1'b0};
    vecs[6] = '{d: {13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 13'sd2, 13'sd4095, 13'sd4095},
                gap: '0, rnd_gap: 1'b0, exp_data: 14'sd8191, exp_sat: 1'b1};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_cnt", int'(dut.cnt), 0);
    rst = 1'b0;
    tick();
    check("rst_inrdy", int'(in_ready), 1);

    for (int i = 0; i < NVEC; i++) begin
      for (int k = 0; k < 8; k++) begin
        g = vecs[i].rnd_gap ? int'($urandom_range(0, 3)) : int'(vecs[i].gap[k]);
        in_valid = 1'b0;
        for (int j = 0; j < g; j++) begin
          tick();
          check($sformatf("v%0d_idle_cnt", i), int'(dut.cnt), k);
        end
        if (k == 7) check($sformatf("v%0d_early", i), int'(out_valid), 0);
        send($signed(vecs[i].d[k]));
      end
      expect_result($sformatf("v%0d", i), int'($signed(vecs[i].exp_data)), int'(vecs[i].exp_sat));
      collect($sformatf("v%0d", i));
    end

    // Back-pressure: result held while in_valid stays high.
    send_n(8, 13'sd2);
    expect_result("bp", 16, 0);
    in_valid = 1'b1;
    in_data  = 13'sd5;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("bp_inrdy", int'(in_ready), 0);
      check("bp_hold", int'(out_data), 16);
      check("bp_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_no_take", int'(dut.cnt), 0);
    check("bp_keep", int'(out_data), 16);
    send_n(8, 13'sd1);
    expect_result("bp_next", 8, 0);
    collect("bp_next");

    // clear mid-accumulation, with a partial presented in the same cycle.
    send_n(5, 13'sd50);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 13'sd50;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_cnt", int'(dut.cnt), 0);
    check("clr_valid", int'(out_valid), 0);
    send_n(8, 13'sd10);
    expect_result("clr", 80, 0);
    collect("clr");

    // clear while a saturated result is pending discards it.
    send_n(8, 13'sd4095);
    expect_result("clrd", 8191, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrd_valid", int'(out_valid), 0);
    check("clrd_sat", int'(out_sat), 0);
    check("clrd_rdy", int'(in_ready), 1);

    // Asynchronous reset mid-cycle while accumulating (cnt=3).
    send_n(3, 13'sd100);
    check("ar_cnt3", int'(dut.cnt), 3);
    #2 rst = 1'b1;
    #1;
    check("ar_cnt", int'(dut.cnt), 0);
    check("ar_valid", int'(out_valid), 0);
    check("ar_data", int'(out_data), 0);
    check("ar_sat", int'(out_sat), 0);
    tick();
    rst = 1'b0;
    send_n(8, 13'sd7);
    expect_result("ar", 56, 0);
    collect("ar");

    // Asynchronous reset while a result is pending.
    send_n(8, 13'sd4095);
    held = out_data;
    check("ard_pend", int'(held), 8191);
    #3 rst = 1'b1;
    #1;
    check("ard_valid", int'(out_valid), 0);
    check("ard_data", int'(out_data), 0);
    check("ard_sat", int'(out_sat), 0);
    tick();
    rst = 1'b0;
    tick();
    check("ard_rdy", int'(in_ready), 1);
    send_n(8, -13'sd2);
    expect_result("ard", -16, 0);
    collect("ard");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
